// File: rtl/io_map_pkg.sv
// io_map_pkg: IO window base, register offsets and UART state encoding
package io_map_pkg;
    localparam logic [15:0] IO_BASE       = 16'hBFD0;
    localparam logic [15:0] OFF_LED       = 16'hF000;
    localparam logic [15:0] OFF_SEG       = 16'hF004;
    localparam logic [15:0] OFF_SW        = 16'hF008;
    localparam logic [15:0] OFF_TIMER     = 16'hF00C;
    localparam logic [15:0] OFF_UART_TX   = 16'hF010;
    localparam logic [15:0] OFF_UART_STAT = 16'hF014;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 transmitter, start is ignored while a frame is in flight
module uart_tx_core
    import io_map_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    uart_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shr;
    logic last;
    assign last = cnt == CW'(CLKS_PER_BIT - 1);
    assign busy = state != ST_IDLE;
    assign txd  = state == ST_START ? 1'b0 : state == ST_DATA ? shr[bit_idx] : 1'b1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shr     <= '0;
        end else begin
            cnt <= (state == ST_IDLE || last) ? '0 : cnt + 1'b1;
            case (state)
                ST_IDLE: if (start) begin
                    state <= ST_START;
                    shr   <= data;
                end
                ST_START: if (last) begin
                    state   <= ST_DATA;
                    bit_idx <= '0;
                end
                ST_DATA: if (last) begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= ST_STOP;
                end
                ST_STOP: if (last) state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/io_dev.sv
// io_dev: zero-wait IO bus responder with LED, 7-seg, switches, timer and UART TX
module io_dev
    import io_map_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int LED_W        = 16,
    parameter int SW_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             io_ce,
    input  logic             io_we,
    input  logic [31:0]      io_addr,
    input  logic [31:0]      io_din,
    output logic [31:0]      io_dout,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic [31:0]      seg,
    output logic             uart_txd
);
    logic [15:0] off;
    logic hit, wr, rd, busy, unused_addr;
    logic [31:0] timer, rd_val;
    logic [SW_W-1:0] sw_q1, sw_q2;
    assign off         = {io_addr[15:2], 2'b00};
    assign unused_addr = ^io_addr[1:0];
    assign hit         = io_ce && io_addr[31:16] == IO_BASE;
    assign wr          = hit && io_we;
    assign rd          = hit && !io_we;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led   <= '0;
            seg   <= '0;
            timer <= '0;
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            if (wr && off == OFF_LED) led <= io_din[LED_W-1:0];
            if (wr && off == OFF_SEG) seg <= io_din;
            timer <= (wr && off == OFF_TIMER) ? io_din : timer + 32'd1;
            sw_q1 <= sw;
            sw_q2 <= sw_q1;
        end
    end
    always_comb
        rd_val = off == OFF_LED       ? 32'(led)    :
                 off == OFF_SEG       ? seg         :
                 off == OFF_SW        ? 32'(sw_q2)  :
                 off == OFF_TIMER     ? timer       :
                 off == OFF_UART_STAT ? {31'd0, busy} : 32'd0;
    assign io_dout = rd ? rd_val : 32'd0;
    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk  (clk),
        .rst_n(rst_n),
        .start(wr && off == OFF_UART_TX),
        .data (io_din[7:0]),
        .busy (busy),
        .txd  (uart_txd)
    );
endmodule

// File: tb/tb_io_dev.sv
// tb_io_dev: directed literal checks plus randomized traffic against a cycle-indexed reference model
module tb_io_dev;
    logic clk = 1'b0, rst_n = 1'b0, io_ce = 1'b0, io_we = 1'b0, uart_txd;
    logic [31:0] io_addr = 32'hBFD0_0000, io_din = 32'd0, io_dout, seg;
    logic [15:0] sw = 16'd0, led;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    io_dev #(.CLKS_PER_BIT(4), .LED_W(16), .SW_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .io_ce(io_ce), .io_we(io_we), .io_addr(io_addr),
        .io_din(io_din), .io_dout(io_dout), .sw(sw), .led(led), .seg(seg), .uart_txd(uart_txd)
    );
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask
    // Model: state after the most recent posedge; the UART frame is a start cycle index plus a byte
    logic [15:0] m_led, m_s1, m_s2;
    logic [31:0] m_seg, m_timer;
    logic [7:0] m_byte;
    logic m_act = 1'b0, seen_rst = 1'b0;
    int m_st = 0, n = 0;
    function automatic logic m_busy(int k);
        return m_act && (k - m_st) < 40;
    endfunction
    function automatic logic exp_txd(int k);
        logic [9:0] f;
        if (!m_busy(k)) return 1'b1;
        f = {1'b1, m_byte, 1'b0};
        return f[(k - m_st) / 4];
    endfunction
    function automatic logic [31:0] exp_dout();
        logic [15:0] o;
        o = {io_addr[15:2], 2'b00};
        if (!(io_ce && !io_we)) return 32'd0;
        case (o)
            16'hF000: return {16'd0, m_led};
            16'hF004: return m_seg;
            16'hF008: return {16'd0, m_s2};
            16'hF00C: return m_timer;
            16'hF014: return {31'd0, m_busy(n)};
            default:  return 32'd0;
        endcase
    endfunction
    initial forever begin
        logic [15:0] o;
        logic wr;
        @(negedge clk);
        if (seen_rst) begin
            chk("m_led", {16'd0, led}, {16'd0, m_led});
            chk("m_seg", seg, m_seg);
            chk("m_txd", {31'd0, uart_txd}, {31'd0, exp_txd(n)});
            chk("m_dout", io_dout, exp_dout());
        end
        o  = {io_addr[15:2], 2'b00};
        wr = io_ce && io_we;
        if (!rst_n) begin
            m_led = 0; m_seg = 0; m_timer = 0; m_s1 = 0; m_s2 = 0; m_act = 0; seen_rst = 1;
        end else begin
            if (wr && o == 16'hF000) m_led = io_din[15:0];
            if (wr && o == 16'hF004) m_seg = io_din;
            m_timer = (wr && o == 16'hF00C) ? io_din : m_timer + 1;
            if (wr && o == 16'hF010 && !m_busy(n)) begin
                m_act = 1; m_st = n + 1; m_byte = io_din[7:0];
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
        n++;
    end
    task automatic drv(input logic r, input logic c, input logic w, input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst_n = r; io_ce = c; io_we = w; io_addr = {16'hBFD0, a}; io_din = d;
    endtask
    task automatic frame(input logic [7:0] b, input bit poll);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            if (poll && i == 10) drv(1, 1, 1, 16'hF010, 32'h33);
            else drv(1, 1, 0, 16'hF014, 0);
            @(negedge clk);
            chk("frame_txd", {31'd0, uart_txd}, {31'd0, f[i / 4]});
            if (!(poll && i == 10)) chk("frame_busy", io_dout, 32'd1);
        end
        drv(1, 1, 0, 16'hF014, 0);
        @(negedge clk);
        chk("frame_done", io_dout, 32'd0);
    endtask
    initial begin
        logic [15:0] tbl [7];
        tbl = '{16'hF000, 16'hF004, 16'hF008, 16'hF00C, 16'hF010, 16'hF014, 16'hF020};
        drv(0, 0, 0, 16'hF000, 0);
        drv(0, 0, 0, 16'hF000, 0);
        @(negedge clk);
        chk("rst_led", {16'd0, led}, 32'd0);
        chk("rst_seg", seg, 32'd0);
        chk("rst_txd", {31'd0, uart_txd}, 32'd1);
        drv(0, 1, 0, 16'hF014, 0);
        @(negedge clk);
        chk("rst_stat", io_dout, 32'd0);
        drv(1, 1, 0, 16'hF00C, 0);
        @(negedge clk);
        chk("rst_timer", io_dout, 32'd0);
        drv(1, 1, 1, 16'hF000, 32'hDEAD_BEEF);
        drv(1, 1, 0, 16'hF000, 0);
        @(negedge clk);
        chk("led_out", {16'd0, led}, 32'h0000_BEEF);
        chk("led_rd", io_dout, 32'h0000_BEEF);
        drv(1, 1, 0, 16'hF020, 0);
        @(negedge clk);
        chk("unmapped", io_dout, 32'd0);
        drv(1, 1, 1, 16'hF008, 32'hFFFF_FFFF);
        drv(1, 1, 0, 16'hF008, 0);
        @(negedge clk);
        chk("sw_ro", io_dout, 32'd0);
        drv(1, 1, 1, 16'hF00C, 32'hFFFF_FFFE);
        drv(1, 1, 0, 16'hF00C, 0);
        @(negedge clk);
        chk("timer0", io_dout, 32'hFFFF_FFFE);
        drv(1, 1, 0, 16'hF00C, 0);
        @(negedge clk);
        chk("timer1", io_dout, 32'hFFFF_FFFF);
        drv(1, 1, 0, 16'hF00C, 0);
        @(negedge clk);
        chk("timer2", io_dout, 32'h0000_0000);
        drv(1, 1, 0, 16'hF008, 0);
        sw = 16'h00A5;
        @(negedge clk);
        chk("sw_lat0", io_dout, 32'd0);
        drv(1, 1, 0, 16'hF008, 0);
        @(negedge clk);
        chk("sw_lat1", io_dout, 32'd0);
        drv(1, 1, 0, 16'hF008, 0);
        @(negedge clk);
        chk("sw_lat2", io_dout, 32'h0000_00A5);
        drv(1, 1, 1, 16'hF010, 32'h1A5);
        frame(8'hA5, 1);
        drv(1, 1, 1, 16'hF010, 32'h5C);
        for (int i = 0; i < 17; i++) drv(1, 0, 0, 16'hF000, 0);
        @(negedge clk);
        chk("mid_bit3", {31'd0, uart_txd}, {31'd0, 1'b1});
        drv(0, 0, 0, 16'hF000, 0);
        drv(1, 1, 0, 16'hF014, 0);
        @(negedge clk);
        chk("abort_busy", io_dout, 32'd0);
        chk("abort_txd", {31'd0, uart_txd}, 32'd1);
        drv(1, 1, 1, 16'hF010, 32'h96);
        frame(8'h96, 0);
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(499) != 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
                tbl[$urandom_range(6)] | 16'($urandom_range(3)), $urandom);
            if ($urandom_range(15) == 0) sw = 16'($urandom);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
